// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: tracks in-flight destinations, drives
// operand forwarding, load-use bubbles, IF/ID squash on taken branches, event counters.
module hazard_ctrl #(
  parameter int RW = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [RW-1:0] id_rn,
  input  logic [RW-1:0] id_rm,
  input  logic [RW-1:0] id_rd_src,
  input  logic          id_rn_use,
  input  logic          id_rm_use,
  input  logic          id_rd_use,
  input  logic [RW-1:0] id_dst,
  input  logic          id_rf_en,
  input  logic          id_load,
  input  logic          branch_taken,
  output logic          pc_le,
  output logic          ifid_le,
  output logic          ifid_clr,
  output logic          nop_sel,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic [1:0]    fwd_c,
  output logic [CW-1:0] stall_count,
  output logic [CW-1:0] flush_count
);

  typedef enum logic [1:0] {HOLD, RUN, STALL} state_t;

  localparam logic [RW-1:0] PC_IDX = RW'(15);

  state_t          state_q, state_d;
  logic            ex_wr_q, ex_ld_q, mem_wr_q, wb_wr_q;
  logic [RW-1:0]   ex_dst_q, mem_dst_q, wb_dst_q;
  logic [CW-1:0]   stall_cnt_q, flush_cnt_q;
  logic            stall_inc, flush_inc, hz;

  logic [RW-1:0]   src [3];
  logic [2:0]      src_use;
  logic [2:0]      match_ex;
  logic [5:0]      fwd_v;

  assign src[0]  = id_rn;
  assign src[1]  = id_rm;
  assign src[2]  = id_rd_src;
  assign src_use = {id_rd_use, id_rm_use, id_rn_use};

  // An EX-stage load cannot forward yet, so it falls through to the MEM/WB compares.
  for (genvar gi = 0; gi < 3; gi++) begin : g_src
    logic live;
    assign live          = src_use[gi] && (src[gi] != PC_IDX);
    assign match_ex[gi]  = live && (ex_dst_q == src[gi]);
    assign fwd_v[2*gi +: 2] =
        !live                                       ? 2'b00 :
        (ex_wr_q && !ex_ld_q && ex_dst_q == src[gi]) ? 2'b01 :
        (mem_wr_q && mem_dst_q == src[gi])           ? 2'b10 :
        (wb_wr_q && wb_dst_q == src[gi])             ? 2'b11 : 2'b00;
  end

  assign fwd_a = fwd_v[1:0];
  assign fwd_b = fwd_v[3:2];
  assign fwd_c = fwd_v[5:4];
  assign hz    = ex_wr_q && ex_ld_q && (|match_ex);

  always_comb begin
    state_d   = state_q;
    pc_le     = 1'b0;
    ifid_le   = 1'b0;
    ifid_clr  = 1'b0;
    nop_sel   = 1'b1;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    case (state_q)
      HOLD: state_d = RUN;
      RUN, STALL: begin
        if (state_q == RUN && hz) begin
          state_d   = STALL;
          stall_inc = 1'b1;
        end else begin
          state_d = RUN;
          pc_le   = 1'b1;
          ifid_le = 1'b1;
          nop_sel = 1'b0;
          if (branch_taken) begin
            ifid_clr  = 1'b1;
            flush_inc = 1'b1;
          end
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= HOLD;
      ex_wr_q     <= 1'b0;
      ex_ld_q     <= 1'b0;
      ex_dst_q    <= '0;
      mem_wr_q    <= 1'b0;
      mem_dst_q   <= '0;
      wb_wr_q     <= 1'b0;
      wb_dst_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ex_wr_q   <= id_rf_en && !nop_sel;
      ex_ld_q   <= id_load && !nop_sel;
      ex_dst_q  <= id_dst;
      mem_wr_q  <= ex_wr_q;
      mem_dst_q <= ex_dst_q;
      wb_wr_q   <= mem_wr_q;
      wb_dst_q  <= mem_dst_q;
      if (stall_inc && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_inc && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage ARM-subset core (IF, ID, EX, MEM, WB).
- Tracks the destination register of each in-flight instruction in an internal EX/MEM/WB shadow pipe.
- Generates operand forwarding selects, inserts load-use bubbles (PC/IF-ID hold plus control-mux NOP select), and squashes the IF/ID register on taken branches.
- Keeps saturating stall and flush event counters.

Parameters:
RW, 4, register index width (16 GPRs; index 15 = PC)
CW, 16, width of stall_count/flush_count

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
id_rn  in  RW  ID-stage first source register
id_rm  in  RW  ID-stage second source register
id_rd_src  in  RW  ID-stage third source (store data register)
id_rn_use, id_rm_use, id_rd_use  in  1 each  source valid flags
id_dst  in  RW  ID-stage destination register (14 for branch-link)
id_rf_en  in  1  ID instruction writes RF (CU output, pre-mux)
id_load  in  1  ID instruction is a load
branch_taken  in  1  branch resolved taken in ID this cycle
pc_le  out  1  PC load enable
ifid_le  out  1  IF/ID load enable
ifid_clr  out  1  IF/ID synchronous clear (insert NOP word)
nop_sel  out  1  1 = control mux drives all-zero control into ID/EX
fwd_a, fwd_b, fwd_c  out  2 each  operand select for rn/rm/rd_src: 00 RF, 01 EX result, 10 MEM result, 11 WB result
stall_count  out  CW  load-use bubbles inserted, saturating
flush_count  out  CW  IF/ID squashes, saturating

Behaviour:
- FSM states: HOLD, RUN, STALL. Reset (reset=0, asynchronous) forces HOLD, clears the shadow pipe (ex/mem/wb write flags = 0, dst = 0, ex_ld = 0) and clears both counters.
- HOLD: pc_le=0, ifid_le=0, nop_sel=1, ifid_clr=0. Lasts one cycle after reset is released, then goes to RUN unconditionally. This allows the ROM to present the instruction at address 0.
- Hazard term hz = ex_wr & ex_ld & (ex_dst matches any used ID source, excluding register 15).
- RUN:
  - hz=1: outputs pc_le=0, ifid_le=0, nop_sel=1, ifid_clr=0; go to STALL; stall_count+1.
  - else branch_taken=1: outputs pc_le=1, ifid_le=1, ifid_clr=1, nop_sel=0; flush_count+1; stay in RUN.
  - else: pc_le=1, ifid_le=1, nop_sel=0, ifid_clr=0.
- STALL: one cycle only. Outputs are as in RUN with hz forced to 0; branch_taken is honoured here. Go to RUN. The load is now in MEM, so its consumer forwards with select 10.
- Simultaneous hz and branch_taken: the stall wins and branch_taken is ignored. The branch is still in ID and re-evaluated in the following STALL cycle.
- All outputs are combinational from state, shadow pipe and ID inputs (same-cycle). Counters and the shadow pipe update on the rising clk edge.
- Shadow pipe, per edge (when not in reset):
  - ex_wr <= id_rf_en & ~nop_sel; ex_ld <= id_load & ~nop_sel; ex_dst <= id_dst.
  - mem <= ex; wb <= mem (wr and dst).
- Forwarding per source, priority EX > MEM > WB > RF:
  - 01 if ex_wr & ~ex_ld & ex_dst==src;
  - else 10 if mem_wr & mem_dst==src;
  - else 11 if wb_wr & wb_dst==src;
  - else 00.
  - Forced to 00 when the use flag is 0 or src==15.
- Counters saturate at all-ones; no wrap.
- Reset asserted mid-STALL: immediately HOLD, pipe cleared, no stall counted for the aborted cycle.

Test Plan:
- Reset: reset=0 for 2 cycles, release -> 1 cycle pc_le=0/nop_sel=1, then pc_le=1, ifid_le=1, nop_sel=0; counters=0, all fwd=00.
- EX/MEM/WB forwarding: ADD r1 (rf_en=1) issued, then id_rn=1 for 3 consecutive cycles (with unrelated instructions between) -> fwd_a=01, then 10, then 11; with id_rn=15 -> 00.
- Load-use: LDR r2 followed by ADD using id_rm=2 -> one cycle pc_le=0, ifid_le=0, nop_sel=1; next cycle fwd_b=10; stall_count=1.
- Branch flush: branch_taken=1 in RUN with no hazard -> ifid_clr=1 for exactly that cycle, pc_le=1, flush_count=1.
- Stall+branch collision: hz=1 and branch_taken=1 together -> ifid_clr=0 that cycle; STALL cycle with branch_taken=1 -> ifid_clr=1; stall_count=1, flush_count=1.
- Saturation and reset mid-stall: force 2^CW+3 stalls -> stall_count=all-ones; assert reset during STALL -> outputs equal HOLD values asynchronously, counters 0.
